// File: rtl/immgen_pipe.sv
// ============================================================================
// Module   : immgen_pipe
// Brief    : Registered RV immediate generator (I/S/B/U/J/Z/SH) with a
//            valid/ready handshake, one output register and one skid entry.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module immgen_pipe #(
    parameter int XLEN  = 64,   // 32 or 64 only
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [2:0]       in_fmt,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    localparam logic [2:0] FMT_I  = 3'd1;
    localparam logic [2:0] FMT_S  = 3'd2;
    localparam logic [2:0] FMT_B  = 3'd3;
    localparam logic [2:0] FMT_U  = 3'd4;
    localparam logic [2:0] FMT_J  = 3'd5;
    localparam logic [2:0] FMT_Z  = 3'd6;
    localparam logic [2:0] FMT_SH = 3'd7;

    logic             or_valid;
    logic [XLEN-1:0]  or_imm;
    logic [TAG_W-1:0] or_tag;
    logic             or_ill;
    logic             sk_valid;
    logic [XLEN-1:0]  sk_imm;
    logic [TAG_W-1:0] sk_tag;
    logic             sk_ill;

    logic [63:0]      imm_full;
    logic [XLEN-1:0]  new_imm;
    logic             new_ill;
    logic             accept;
    logic             emit;

    // Built at 64 bits and truncated so no zero-width replication appears for XLEN=32.
    always_comb begin
        imm_full = 64'd0;
        new_ill  = 1'b0;
        case (in_fmt)
            FMT_I:  imm_full = {{52{in_instr[31]}}, in_instr[31:20]};
            FMT_S:  imm_full = {{52{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            FMT_B:  imm_full = {{51{in_instr[31]}}, in_instr[31], in_instr[7],
                                in_instr[30:25], in_instr[11:8], 1'b0};
            FMT_U:  imm_full = {{32{in_instr[31]}}, in_instr[31:12], 12'd0};
            FMT_J:  imm_full = {{43{in_instr[31]}}, in_instr[31], in_instr[19:12],
                                in_instr[20], in_instr[30:21], 1'b0};
            FMT_Z:  imm_full = {59'd0, in_instr[19:15]};
            FMT_SH: begin
                if (XLEN == 64) begin
                    imm_full = {58'd0, in_instr[25:20]};
                end else begin
                    imm_full = {59'd0, in_instr[24:20]};
                    new_ill  = in_instr[25];
                end
            end
            default: imm_full = 64'd0;
        endcase
        new_imm = imm_full[XLEN-1:0];
    end

    assign in_ready = !sk_valid;
    assign accept   = in_valid && in_ready;
    assign emit     = or_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            or_valid <= 1'b0;
            or_imm   <= '0;
            or_tag   <= '0;
            or_ill   <= 1'b0;
            sk_valid <= 1'b0;
            sk_imm   <= '0;
            sk_tag   <= '0;
            sk_ill   <= 1'b0;
        end else if (flush) begin
            or_valid <= 1'b0;
            sk_valid <= 1'b0;
        end else if (emit) begin
            if (sk_valid) begin
                or_imm   <= sk_imm;
                or_tag   <= sk_tag;
                or_ill   <= sk_ill;
                sk_valid <= 1'b0;
            end else if (accept) begin
                or_imm   <= new_imm;
                or_tag   <= in_tag;
                or_ill   <= new_ill;
            end else begin
                or_valid <= 1'b0;
            end
        end else if (accept) begin
            // Skid only fills when the output register is already occupied.
            if (!or_valid) begin
                or_valid <= 1'b1;
                or_imm   <= new_imm;
                or_tag   <= in_tag;
                or_ill   <= new_ill;
            end else begin
                sk_valid <= 1'b1;
                sk_imm   <= new_imm;
                sk_tag   <= in_tag;
                sk_ill   <= new_ill;
            end
        end
    end

    assign out_valid   = or_valid;
    assign out_imm     = or_imm;
    assign out_tag     = or_tag;
    assign out_illegal = or_ill;

endmodule

`default_nettype wire

// File: tb/tb_immgen_pipe.sv
// ============================================================================
// Module   : tb_immgen_pipe
// Brief    : Table-driven scoreboard bench for immgen_pipe (XLEN=64 main, XLEN=32 shamt).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_immgen_pipe;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [31:0] in_instr;
    logic [2:0]  in_fmt;
    logic [7:0]  in_tag;
    logic        in_ready, out_valid, out_illegal;
    logic [63:0] out_imm;
    logic [7:0]  out_tag;
    logic        in_ready32, out_valid32, out_illegal32;
    logic [31:0] out_imm32;
    logic [7:0]  out_tag32;

    logic [63:0] cur_imm;
    logic        cur_ill;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  fmt;
        logic [63:0] imm;
        logic        ill;
    } vec_t;

    typedef struct {
        logic [63:0] imm;
        logic [7:0]  tag;
        logic        ill;
    } exp_t;

    vec_t tbl[14];
    exp_t q[$];

    immgen_pipe #(.XLEN(64), .TAG_W(8)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_fmt(in_fmt), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .out_tag(out_tag), .out_illegal(out_illegal)
    );

    immgen_pipe #(.XLEN(32), .TAG_W(8)) dut32 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32), .in_instr(in_instr),
        .in_fmt(in_fmt), .in_tag(in_tag),
        .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32),
        .out_tag(out_tag32), .out_illegal(out_illegal32)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: pop on emit, push on accept (never while flush/reset).
    always @(negedge clk) begin
        if (out_valid && out_ready && !reset) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_out: got tag 0x%0h with empty queue", out_tag);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("out_tag", {56'd0, out_tag}, {56'd0, e.tag});
                chk("out_imm", out_imm, e.imm);
                chk("out_illegal", {63'd0, out_illegal}, {63'd0, e.ill});
            end
        end
        if (in_valid && in_ready && !flush && !reset)
            q.push_back('{imm: cur_imm, tag: in_tag, ill: cur_ill});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input int idx, input logic [7:0] tag);
        in_valid = 1'b1;
        in_instr = tbl[idx].instr;
        in_fmt   = tbl[idx].fmt;
        in_tag   = tag;
        cur_imm  = tbl[idx].imm;
        cur_ill  = tbl[idx].ill;
    endtask

    // Returns just after the edge on which the beat was taken.
    task automatic wait_accept();
        int budget = 50;
        logic acc;
        do begin
            acc = in_ready;
            tick();
            budget--;
        end while (!acc && budget > 0);
        if (!acc) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: in_ready never rose for tag 0x%0h", in_tag);
        end
    endtask

    task automatic offer(input int idx, input logic [7:0] tag);
        set_beat(idx, tag);
        wait_accept();
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int budget = 50;
        while (q.size() != 0 && budget > 0) begin
            tick();
            budget--;
        end
        tick();
        chk("drain_queue_empty", 64'(q.size()), 64'd0);
    endtask

    initial begin
        tbl[0]  = '{32'hFFFFFFFF, 3'd0, 64'h0, 1'b0};
        tbl[1]  = '{32'hFFF00093, 3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        tbl[2]  = '{32'h7FF00093, 3'd1, 64'h7FF, 1'b0};
        tbl[3]  = '{32'hFE20BC23, 3'd2, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0};
        tbl[4]  = '{32'h00112423, 3'd2, 64'h8, 1'b0};
        tbl[5]  = '{32'hFE000EE3, 3'd3, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0};
        tbl[6]  = '{32'h00000463, 3'd3, 64'h8, 1'b0};
        tbl[7]  = '{32'h800000B7, 3'd4, 64'hFFFF_FFFF_8000_0000, 1'b0};
        tbl[8]  = '{32'h12345037, 3'd4, 64'h1234_5000, 1'b0};
        tbl[9]  = '{32'h001000EF, 3'd5, 64'h800, 1'b0};
        tbl[10] = '{32'h800000EF, 3'd5, 64'hFFFF_FFFF_FFF0_0000, 1'b0};
        tbl[11] = '{32'h800F8073, 3'd6, 64'h1F, 1'b0};
        tbl[12] = '{32'h02100013, 3'd7, 64'h21, 1'b0};
        tbl[13] = '{32'h01F00013, 3'd7, 64'h1F, 1'b0};

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_instr = 32'd0; in_fmt = 3'd0; in_tag = 8'd0; cur_imm = 64'd0; cur_ill = 1'b0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_imm", out_imm, 64'd0);
        chk("rst_out_tag", {56'd0, out_tag}, 64'd0);
        chk("rst_out_illegal", {63'd0, out_illegal}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

        // Back-to-back stream: one beat per cycle with out_ready held high.
        for (int i = 0; i < 14; i++) begin
            offer(i, 8'(8'h10 + i));
            chk("stream_out_valid", {63'd0, out_valid}, 64'd1);
        end
        idle();
        drain();

        // XLEN=32 shamt with ir[25] set: truncated amount, illegal flagged.
        offer(12, 8'h21);
        idle();
        chk("sh32_valid", {63'd0, out_valid32}, 64'd1);
        chk("sh32_imm", {32'd0, out_imm32}, 64'd1);
        chk("sh32_illegal", {63'd0, out_illegal32}, 64'd1);
        drain();

        // Backpressure: tags 1,2 taken, 3 held off, then ordered release.
        out_ready = 1'b0;
        offer(5, 8'd1);
        offer(7, 8'd2);
        set_beat(9, 8'd3);
        tick(); tick();
        chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
        chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
        chk("bp_hold_tag", {56'd0, out_tag}, 64'd1);
        chk("bp_hold_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
        out_ready = 1'b1;
        wait_accept();
        idle();
        drain();

        // Flush with both entries full and a beat offered.
        out_ready = 1'b0;
        offer(1, 8'd4);
        offer(2, 8'd5);
        set_beat(3, 8'd6);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle();
        q.delete();
        chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
        out_ready = 1'b1;
        offer(8, 8'd9);
        idle();
        drain();

        // Flush while empty: beat offered with in_ready=1 must vanish.
        set_beat(4, 8'h55);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle();
        tick();
        chk("flush_empty_out_valid", {63'd0, out_valid}, 64'd0);

        // Reset with both entries full.
        out_ready = 1'b0;
        offer(7, 8'd7);
        offer(10, 8'd8);
        set_beat(11, 8'd10);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        q.delete();
        chk("rst2_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst2_out_imm", out_imm, 64'd0);
        chk("rst2_out_tag", {56'd0, out_tag}, 64'd0);
        chk("rst2_in_ready", {63'd0, in_ready}, 64'd1);
        out_ready = 1'b1;
        offer(13, 8'h77);
        idle();
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
